// File: rtl/lsq_mem_port_arbiter.sv
// Shares the single data-memory request port between the load pipe and the store queue drain.
// Optional store starvation guard: define LSQ_ARB_STARVATION_GUARD_EN to enable the load-streak counter.
module lsq_mem_port_arbiter #(
   parameter int MAX_OUTSTANDING = 4,
   parameter int MAX_LOAD_STREAK = 8
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 ld_req_valid,
   output logic                                 ld_req_ready,
   input  logic                                 sq_valid,
   input  logic                                 sq_full,
   input  logic                                 sq_empty,
   output logic                                 sq_pop,
   input  logic                                 fence_req,
   output logic                                 fence_done,
   output logic                                 mem_req_valid,
   output logic                                 mem_req_is_store,
   input  logic                                 mem_req_ready,
   input  logic                                 mem_resp_valid,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
   output logic                                 busy
);

   localparam int OW = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic [1:0] {
      NORMAL = 2'd0,
      DRAIN  = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t state;

   logic cap;
   logic store_pri;
   logic streak_hit;
   logic sel_store;
   logic sel_load;
   logic accept;
   logic drain_complete;

   // Handshake: a memory request transfers in a cycle where mem_req_valid and mem_req_ready
   // are both high; that same cycle pulses sq_pop or ld_req_ready toward the chosen source.
   assign cap = (outstanding == OW'(MAX_OUTSTANDING));

`ifdef LSQ_ARB_STARVATION_GUARD_EN
   localparam int SW = $clog2(MAX_LOAD_STREAK + 1);

   logic [SW-1:0] streak;

   assign streak_hit = (streak == SW'(MAX_LOAD_STREAK));

   // Counts loads granted past a waiting store; any store grant or idle store queue resets it.
   always_ff @(posedge clk) begin
      if (rst) begin
         streak <= '0;
      end else if (sq_pop || !sq_valid) begin
         streak <= '0;
      end else if (ld_req_ready && !streak_hit) begin
         streak <= streak + SW'(1);
      end
   end
`else
   assign streak_hit = 1'b0;
`endif

   assign store_pri = sq_full | streak_hit;

   always_comb begin
      sel_store = 1'b0;
      sel_load  = 1'b0;
      case (state)
         NORMAL: begin
            sel_store = sq_valid & (store_pri | ~ld_req_valid);
            sel_load  = ~sel_store & ld_req_valid;
         end
         DRAIN: begin
            sel_store = sq_valid;
         end
         default: begin
            sel_store = 1'b0;
            sel_load  = 1'b0;
         end
      endcase
   end

   assign mem_req_valid    = (sel_store | sel_load) & ~cap;
   assign mem_req_is_store = sel_store;
   assign accept           = mem_req_valid & mem_req_ready;
   assign sq_pop           = accept & sel_store;
   assign ld_req_ready     = accept & ~sel_store;

   always_ff @(posedge clk) begin
      if (rst) begin
         outstanding <= '0;
      end else if (accept && !mem_resp_valid) begin
         outstanding <= outstanding + OW'(1);
      end else if (!accept && mem_resp_valid && (outstanding != '0)) begin
         outstanding <= outstanding - OW'(1);
      end
   end

   // The fence is complete only once nothing is queued, in flight, or being issued right now.
   assign drain_complete = sq_empty & (outstanding == '0) & ~accept;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= NORMAL;
         fence_done <= 1'b0;
      end else begin
         case (state)
            NORMAL: begin
               fence_done <= 1'b0;
               if (fence_req) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (drain_complete) begin
                  state      <= DONE;
                  fence_done <= 1'b1;
               end
            end
            DONE: begin
               state      <= NORMAL;
               fence_done <= 1'b0;
            end
            default: begin
               state      <= NORMAL;
               fence_done <= 1'b0;
            end
         endcase
      end
   end

   assign busy = (state != NORMAL) | (outstanding != '0);

   a_no_resp_when_idle : assert property (@(posedge clk) disable iff (rst)
      !(mem_resp_valid && (outstanding == '0)));

endmodule

// File: tb/tb_lsq_mem_port_arbiter.sv
// Randomized and directed checks of lsq_mem_port_arbiter against a cycle-level reference model.
module tb_lsq_mem_port_arbiter;
  localparam int MAXO     = 4;
  localparam int MAXS     = 8;
  localparam int SQ_DEPTH = 4;
`ifdef LSQ_ARB_STARVATION_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       ld_req_valid = 1'b0;
  logic       ld_req_ready;
  logic       sq_valid = 1'b0;
  logic       sq_full = 1'b0;
  logic       sq_empty = 1'b1;
  logic       sq_pop;
  logic       fence_req = 1'b0;
  logic       fence_done;
  logic       mem_req_valid;
  logic       mem_req_is_store;
  logic       mem_req_ready = 1'b0;
  logic       mem_resp_valid = 1'b0;
  logic [2:0] outstanding;
  logic       busy;

  lsq_mem_port_arbiter #(.MAX_OUTSTANDING(MAXO), .MAX_LOAD_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready),
    .sq_valid(sq_valid), .sq_full(sq_full), .sq_empty(sq_empty), .sq_pop(sq_pop),
    .fence_req(fence_req), .fence_done(fence_done),
    .mem_req_valid(mem_req_valid), .mem_req_is_store(mem_req_is_store),
    .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
    .outstanding(outstanding), .busy(busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  // reference model: in-flight count, loads granted past a waiting store, fence phase
  int m_out = 0;
  int m_streak = 0;
  int m_phase = 0;  // 0 idle, 1 draining for a fence, 2 reporting completion
  int sq_cnt = 0;
  bit rel = 1'b0;
  bit push = 1'b0;

  bit obs_pop, obs_ld, obs_done, saw_done;
  int pops, loads, drain_loads;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    bit e_st, e_ld, e_val, e_acc, pri;
    int resp;
    int nxt_phase;
    @(negedge clk);
    sq_empty = (sq_cnt == 0);
    sq_full  = (sq_cnt == SQ_DEPTH);
    sq_valid = (sq_cnt != 0) && rel;
    if (m_out == 0) mem_resp_valid = 1'b0;
    #1;
    pri  = sq_full || (GUARD && (m_streak == MAXS));
    e_st = 1'b0;
    e_ld = 1'b0;
    if (m_phase == 0) begin
      e_st = sq_valid && (pri || !ld_req_valid);
      e_ld = !e_st && ld_req_valid;
    end else if (m_phase == 1) begin
      e_st = sq_valid;
    end
    e_val = (e_st || e_ld) && (m_out < MAXO);
    e_acc = e_val && mem_req_ready;
    check("mem_req_valid", mem_req_valid, e_val);
    check("mem_req_is_store", mem_req_is_store, e_st);
    check("sq_pop", sq_pop, e_acc && e_st);
    check("ld_req_ready", ld_req_ready, e_acc && e_ld);
    check("outstanding", outstanding, m_out);
    check("fence_done", fence_done, m_phase == 2);
    check("busy", busy, (m_phase != 0) || (m_out != 0));
    obs_pop  = sq_pop;
    obs_ld   = ld_req_ready;
    obs_done = fence_done;
    if (fence_done) saw_done = 1'b1;
    if (sq_pop) pops++;
    if (ld_req_ready) loads++;
    if (m_phase == 1 && ld_req_ready) drain_loads++;
    resp = mem_resp_valid ? 1 : 0;
    @(posedge clk);
    if (rst) begin
      m_out = 0;
      m_streak = 0;
      m_phase = 0;
    end else begin
      nxt_phase = m_phase;
      if (m_phase == 0 && fence_req) nxt_phase = 1;
      else if (m_phase == 1 && sq_empty && m_out == 0 && !e_acc) nxt_phase = 2;
      else if (m_phase == 2) nxt_phase = 0;
      m_phase = nxt_phase;
      m_out = m_out + (e_acc ? 1 : 0) - resp;
      if (GUARD) begin
        if ((e_acc && e_st) || !sq_valid) m_streak = 0;
        else if (e_acc && e_ld && m_streak < MAXS) m_streak++;
      end
    end
    if (e_acc && e_st) sq_cnt--;
    if (push && sq_cnt < SQ_DEPTH) sq_cnt++;
    #1;
  endtask

  task automatic reset_dut();
    ld_req_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    fence_req = 1'b0; rel = 1'b0; push = 1'b0; sq_cnt = 0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int first_pop, second_pop;
    repeat (2) @(posedge clk);
    #1;
    reset_dut();
    check("reset_out", outstanding, 0);
    check("reset_busy", busy, 0);
    check("reset_done", fence_done, 0);

    // load beats a non-urgent store; full queue flips priority
    sq_cnt = 1; rel = 1'b1; ld_req_valid = 1'b1; mem_req_ready = 1'b1;
    step();
    check("prio_ld_ready", obs_ld, 1);
    check("prio_ld_pop", obs_pop, 0);
    sq_cnt = SQ_DEPTH;
    step();
    check("full_pop", obs_pop, 1);
    check("full_ld_ready", obs_ld, 0);

    // starvation
    reset_dut();
    sq_cnt = 2; rel = 1'b1; ld_req_valid = 1'b1; mem_req_ready = 1'b1;
    first_pop = -1; second_pop = -1; pops = 0;
    for (int i = 0; i < 50; i++) begin
      mem_resp_valid = 1'b1;
      step();
      if (obs_pop && first_pop < 0) first_pop = i;
      else if (obs_pop && second_pop < 0) second_pop = i;
    end
    if (GUARD) begin
      check("starve_first_pop", first_pop, MAXS);
      check("starve_second_pop", second_pop, 2 * MAXS + 1);
    end else begin
      check("strict_load_pops", pops, 0);
    end

    // outstanding cap
    reset_dut();
    ld_req_valid = 1'b1; mem_req_ready = 1'b1; loads = 0;
    repeat (6) step();
    check("cap_accepts", loads, MAXO);
    check("cap_out", outstanding, MAXO);
    check("cap_valid", mem_req_valid, 0);
    mem_resp_valid = 1'b1;
    step();
    mem_resp_valid = 1'b0; loads = 0;
    step();
    check("cap_reaccept", loads, 1);
    ld_req_valid = 1'b0; mem_resp_valid = 1'b1;
    repeat (2) step();
    check("drop_to_two", outstanding, 2);
    ld_req_valid = 1'b1; mem_resp_valid = 1'b1;
    step();
    check("simul_accept", obs_ld, 1);
    check("simul_out", outstanding, 2);

    // fence drain
    reset_dut();
    sq_cnt = 2; rel = 1'b0; ld_req_valid = 1'b1; mem_req_ready = 1'b1;
    step();
    rel = 1'b1; fence_req = 1'b1; pops = 0; drain_loads = 0; saw_done = 1'b0;
    for (int i = 0; i < 40 && !saw_done; i++) begin
      mem_resp_valid = (sq_cnt == 0);
      step();
    end
    fence_req = 1'b0; mem_resp_valid = 1'b0;
    check("fence_done_seen", saw_done, 1);
    check("fence_pops", pops, 2);
    check("fence_no_loads", drain_loads, 0);
    step();
    check("fence_loads_resume", obs_ld, 1);

    // reset during drain
    reset_dut();
    ld_req_valid = 1'b1; mem_req_ready = 1'b1;
    step();
    ld_req_valid = 1'b0; fence_req = 1'b1;
    repeat (3) step();
    saw_done = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0; fence_req = 1'b0;
    check("rst_drain_out", outstanding, 0);
    check("rst_drain_busy", busy, 0);
    repeat (5) step();
    check("rst_drain_no_done", saw_done, 0);

    // random traffic
    reset_dut();
    for (int i = 0; i < 800; i++) begin
      ld_req_valid   = ($urandom_range(0, 3) != 0);
      rel            = ($urandom_range(0, 3) != 0);
      push           = ($urandom_range(0, 2) == 0);
      mem_req_ready  = ($urandom_range(0, 4) != 0);
      mem_resp_valid = ($urandom_range(0, 1) == 1);
      if (!fence_req && $urandom_range(0, 40) == 0) fence_req = 1'b1;
      step();
      if (obs_done) fence_req = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/lsq_mem_port_arbiter.md
Name: lsq_mem_port_arbiter

Overview:
Sequences the single data-memory request port shared by the load pipe and the store queue drain. Arbitrates each cycle between an issuing load and the oldest released store. Forces store priority when the store queue is full or when stores have waited too long. Implements fence drain sequencing and caps outstanding memory requests.

Parameters:
MAX_OUTSTANDING, 4, max accepted-but-uncompleted memory requests (1..15)
MAX_LOAD_STREAK, 8, consecutive loads granted while a store waits before the store is forced (1..255)

Ports:
clk  in  1  clock
rst  in  1  reset
ld_req_valid  in  1  load pipe has a request
ld_req_ready  out  1  load accepted this cycle
sq_valid  in  1  oldest store queue entry valid and released
sq_full  in  1  store queue full
sq_empty  in  1  store queue empty
sq_pop  out  1  store accepted this cycle; pops store queue
fence_req  in  1  level; held by requester until fence_done
fence_done  out  1  one-cycle pulse when fence complete
mem_req_valid  out  1  request presented to memory port
mem_req_is_store  out  1  1 = store selected, 0 = load
mem_req_ready  in  1  memory port accepts
mem_resp_valid  in  1  one outstanding request completed
outstanding  out  $clog2(MAX_OUTSTANDING+1)  current outstanding count
busy  out  1  state != NORMAL or outstanding != 0

Behaviour:
- rst is synchronous, active-high; clock is clk. Reset: state=NORMAL, outstanding=0, streak=0, fence_done=0. Combinational outputs are 0 with no inputs asserted.
- cap = (outstanding == MAX_OUTSTANDING). A response in the same cycle does not lift cap.
- Selection (combinational, zero latency). store_pri = sq_full | (streak == MAX_LOAD_STREAK).
  - NORMAL: store selected if sq_valid & (store_pri | ~ld_req_valid). Otherwise load selected if ld_req_valid.
  - DRAIN: only stores are selectable; loads are blocked.
  - DONE: nothing is selected.
- mem_req_valid = (store or load selected) & ~cap. mem_req_is_store = store selected.
- accept = mem_req_valid & mem_req_ready. sq_pop = accept & is_store. ld_req_ready = accept & ~is_store.
- Outstanding counter:
  - +1 on accept, -1 on mem_resp_valid; both in the same cycle leaves it unchanged.
  - mem_resp_valid with outstanding==0 is illegal (assertion); the counter holds at 0.
- Streak counter:
  - Increments (saturating at MAX_LOAD_STREAK) on an accepted load while sq_valid=1.
  - Clears on sq_pop, or in any cycle with sq_valid=0.
- FSM:
  - NORMAL -> DRAIN when fence_req=1. Selection in that same cycle still uses NORMAL rules.
  - DRAIN -> DONE when sq_empty & outstanding==0 & ~accept, all in the same cycle.
  - DONE: fence_done=1 for exactly one cycle (registered, asserted while in DONE), then -> NORMAL.
  - fence_req is sampled only in NORMAL. In the NORMAL cycle after DONE, a still-high fence_req starts a new fence.
- Reset during DRAIN/DONE returns to NORMAL with no fence_done pulse; outstanding is cleared.
- MAX_OUTSTANDING=1: requests strictly alternate with responses.

Optional Feature:
LSQ_ARB_STARVATION_GUARD_EN
- Defined: streak counter present; store_pri includes the streak term as described.
- Undefined: no streak counter (no flops); store_pri = sq_full only, giving strict load priority otherwise.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then ld_req_valid=1, sq_valid=1, sq_full=0, mem_req_ready=1 -> mem_req_is_store=0, ld_req_ready=1, sq_pop=0; with sq_full=1 -> sq_pop=1, ld_req_ready=0.
- Starvation (macro on, MAX_LOAD_STREAK=8): loads continuous, sq_valid=1, resp every cycle -> 8 loads granted, 9th cycle sq_pop=1, streak returns to 0. Macro off -> no sq_pop over 50 cycles.
- Outstanding cap (MAX_OUTSTANDING=4): ld_req_valid=1, no responses -> 4 accepts, then mem_req_valid=0 and outstanding=4. One mem_resp_valid -> next cycle one more accept.
- Simultaneous accept and mem_resp_valid at outstanding=2 -> stays 2.
- Fence: 2 stores queued, 1 load outstanding, fence_req=1 with ld_req_valid=1 -> no further loads; 2 sq_pops. After last response and sq_empty, fence_done pulses 1 cycle, then loads resume.
- Assert rst during DRAIN -> next cycle state NORMAL, outstanding=0, fence_done never pulses.
